keypad_scanner: RTL
===================

Name: keypad_scanner

Overview:
Scans a 4x4 active-low matrix keypad and produces the keypad-entry interface consumed by the lock FSM: a 4-bit key code on `entry` plus a single-cycle `enter_btn` strobe per debounced press. It sits between the keypad pins and the lock controller. It handles column drive, row synchronisation, debounce, ghost/multi-key rejection and release detection, so the lock sees exactly one strobe per physical press.

Parameters:
- SCAN_DIV, 16: clock cycles each column is driven (dwell); legal range >= 4.
- DEBOUNCE_SCANS, 3: consecutive identical full-scan results required to accept a press or a release; legal range >= 2.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- row_in  input  4  keypad rows, active-low, externally pulled up, asynchronous.
- col_out  output  4  column drive, active-low, exactly one bit low at all times.
- entry  output  4  key code of the last accepted press; held until the next accepted press.
- enter_btn  output  1  one-cycle strobe; `entry` is valid while high.
- key_held  output  1  high from acceptance until the release is debounced.
- multi_key  output  1  high for one cycle after any full scan that saw more than one key.

Behaviour:
- Interface decision: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- Reset values:
  - col_out = 4'b1110 (column 0 driven)
  - entry = 0, enter_btn = 0, key_held = 0, multi_key = 0
  - FSM in IDLE, all counters 0
  - row synchroniser flops = 4'b1111
- row_in passes through a 2-flop synchroniser before any use.
- Column scan:
  - Dwell counter runs 0..SCAN_DIV-1 per column; column index runs 0..3 and wraps to 0.
  - col_out = ~(1 << col_idx), registered.
  - Rows are sampled only on the last dwell cycle (dwell == SCAN_DIV-1), which allows settle plus synchroniser latency.
- Key code = 4*row_idx + col_idx, where row_idx is the index of the low row bit.
- Scan result: accumulated over the 4 columns and evaluated on the last dwell cycle of column 3 (`scan_done`). The result is one of:
  - NONE: no low rows.
  - SINGLE(code): exactly one low bit across the whole scan.
  - MULTI: two or more low bits. Sets multi_key for one cycle and is treated as "key present, code invalid".
- Debounce FSM (`cnt` counts scans; it updates only on scan_done edges):
  - IDLE: SINGLE(k) -> CAND with cand=k, cnt=1. NONE or MULTI -> stay in IDLE.
  - CAND:
    - SINGLE(k) with k==cand -> cnt+1. When cnt+1 == DEBOUNCE_SCANS: entry <= cand, enter_btn <= 1, key_held <= 1, go to PRESSED.
    - SINGLE(k) with k!=cand -> cand=k, cnt=1.
    - NONE -> IDLE.
    - MULTI -> IDLE.
  - PRESSED: NONE -> RELEASE with cnt=1. SINGLE or MULTI -> stay in PRESSED; no new strobe.
  - RELEASE:
    - NONE -> cnt+1. When cnt+1 == DEBOUNCE_SCANS: key_held <= 0, go to IDLE.
    - SINGLE or MULTI -> back to PRESSED, with no strobe.
- enter_btn is registered: high exactly the one cycle after the qualifying scan_done, then low. A held key never re-strobes. Rollover to a second key is ignored until full release.
- Latency: a press that is stable from a scan boundary strobes 1 cycle after the end of its DEBOUNCE_SCANS-th full scan, i.e. DEBOUNCE_SCANS*4*SCAN_DIV + 1 cycles.
- entry changes only in the same cycle enter_btn rises. It is never 'x'.
- rst_n asserted mid-operation: all state and outputs return to reset values immediately, with no strobe. After deassertion, scanning restarts at column 0, dwell 0.
- Counter widths: $clog2(SCAN_DIV) and $clog2(DEBOUNCE_SCANS+1). No wrap-around occurs in cnt because it saturates at the transition point.

Decomposition:
- Package `keypad_pkg`: FSM state enum (IDLE, CAND, PRESSED, RELEASE); scan-result enum (NONE, SINGLE, MULTI); KEY_W = 4; ROWS = 4; COLS = 4.
- One natural sub-module, `keypad_col_scan`: owns the dwell counter, column index and col_out, and outputs `sample_en`, `col_idx` and `scan_done`.
- The synchroniser, result accumulator and debounce FSM stay in keypad_scanner.

Test Plan (SCAN_DIV=4, DEBOUNCE_SCANS=3; one scan = 16 cycles):
- Reset: hold rst_n=0 mid-scan -> col_out=4'b1110, entry=0, enter_btn=0, key_held=0 in the same cycle. After release, col_out walks 1110, 1101, 1011, 0111, each for 4 cycles.
- Single press, code 6 (row 1 low whenever col_out[2]==0), held for 20 scans -> exactly one enter_btn pulse, 1 cycle after the 3rd scan_done, with entry=6 and key_held=1. key_held falls after 3 released scans.
- Bounce: code 9 present 2 scans, absent 1, present 3 -> no pulse after the first 2 scans; exactly one pulse after the final 3rd scan.
- Ghost: codes 1 and 2 pressed together for 10 scans -> multi_key pulses every scan; no enter_btn.
- Sequence 1, 2, 3, 4 (each pressed 4 scans, released 4 scans) -> four strobes with entry 1, 2, 3, 4 in order. In an integrated bench with the lock, the lock reaches unlock=1.
- Reset during CAND (after 2 scans of code 4), then keep the key pressed -> no strobe during reset. A fresh 3-scan debounce is required before the pulse, with entry=4.

Source files
------------

// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types, sizes and row-decode helpers for the keypad scanner
package keypad_pkg;
    localparam int KEY_W = 4;
    localparam int ROWS  = 4;
    localparam int COLS  = 4;

    typedef enum logic [1:0] {IDLE, CAND, PRESSED, RELEASE} state_t;
    typedef enum logic [1:0] {NONE, SINGLE, MULTI} result_t;

    function automatic logic [2:0] low_count(input logic [ROWS-1:0] rows);
        low_count = '0;
        for (int i = 0; i < ROWS; i++) low_count = low_count + {2'b00, ~rows[i]};
    endfunction

    function automatic logic [1:0] low_idx(input logic [ROWS-1:0] rows);
        low_idx = '0;
        for (int i = ROWS - 1; i >= 0; i--) if (!rows[i]) low_idx = 2'(i);
    endfunction
endpackage

// File: rtl/keypad_col_scan.sv
// keypad_col_scan: column drive with per-column dwell counter and scan strobes
module keypad_col_scan
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic [COLS-1:0] col_out,
    output logic [1:0]      col_idx,
    output logic            sample_en,
    output logic            scan_done
);
    localparam int DW = $clog2(SCAN_DIV);

    logic [DW-1:0]   r_dwell;
    logic [1:0]      r_col;
    logic [COLS-1:0] r_col_out;

    assign sample_en = r_dwell == DW'(SCAN_DIV - 1);
    assign scan_done = sample_en && r_col == 2'd3;
    assign col_out   = r_col_out;
    assign col_idx   = r_col;

    // advance the column after its last dwell cycle; drive stays one-cold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dwell   <= '0;
            r_col     <= '0;
            r_col_out <= 4'b1110;
        end else begin
            r_dwell <= sample_en ? '0 : r_dwell + 1'b1;
            if (sample_en) begin
                r_col     <= r_col + 1'b1;
                r_col_out <= {r_col_out[COLS-2:0], r_col_out[COLS-1]};
            end
        end
    end
endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 keypad scan, debounce and ghost rejection producing one strobe per press
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 16,
    parameter int DEBOUNCE_SCANS = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [ROWS-1:0]  row_in,
    output logic [COLS-1:0]  col_out,
    output logic [KEY_W-1:0] entry,
    output logic             enter_btn,
    output logic             key_held,
    output logic             multi_key
);
    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);

    logic             w_sample_en, w_scan_done;
    logic [1:0]       w_col_idx;
    logic [ROWS-1:0]  r_sync1, r_sync2;
    logic [1:0]       r_acc_n;
    logic [KEY_W-1:0] r_acc_code;
    logic [2:0]       w_tot;
    logic [KEY_W-1:0] w_code;
    result_t          w_res;
    state_t           r_state, w_state;
    logic [CW-1:0]    r_cnt, w_cnt;
    logic [KEY_W-1:0] r_cand, w_cand, r_entry, w_entry;
    logic             r_btn, w_btn, r_held, w_held, r_multi, w_multi;

    keypad_col_scan #(.SCAN_DIV(SCAN_DIV)) u_col_scan (
        .clk      (clk),
        .rst_n    (rst_n),
        .col_out  (col_out),
        .col_idx  (w_col_idx),
        .sample_en(w_sample_en),
        .scan_done(w_scan_done)
    );

    assign w_tot   = {1'b0, r_acc_n} + low_count(r_sync2);
    assign w_res   = w_tot == 3'd0 ? NONE : w_tot == 3'd1 ? SINGLE : MULTI;
    assign w_code  = r_acc_n != 2'd0 ? r_acc_code : {low_idx(r_sync2), w_col_idx};

    assign entry     = r_entry;
    assign enter_btn = r_btn;
    assign key_held  = r_held;
    assign multi_key = r_multi;

    // two-flop synchroniser for the asynchronous row inputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
        end else begin
            r_sync1 <= row_in;
            r_sync2 <= r_sync1;
        end
    end

    // accumulate low-row count (saturating at 2) and first key code across one full scan
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc_n    <= '0;
            r_acc_code <= '0;
        end else if (w_sample_en) begin
            r_acc_n    <= w_scan_done ? 2'd0 : (w_tot > 3'd1 ? 2'd2 : w_tot[1:0]);
            r_acc_code <= w_scan_done ? '0 : w_code;
        end
    end

    // debounce state and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_cand  <= '0;
            r_entry <= '0;
            r_btn   <= 1'b0;
            r_held  <= 1'b0;
            r_multi <= 1'b0;
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_cand  <= w_cand;
            r_entry <= w_entry;
            r_btn   <= w_btn;
            r_held  <= w_held;
            r_multi <= w_multi;
        end
    end

    // debounce next-state: acts only on completed scans
    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        w_cand  = r_cand;
        w_entry = r_entry;
        w_btn   = 1'b0;
        w_held  = r_held;
        w_multi = w_scan_done && w_res == MULTI;
        if (w_scan_done) begin
            case (r_state)
                IDLE: if (w_res == SINGLE) begin
                    w_state = CAND;
                    w_cand  = w_code;
                    w_cnt   = CW'(1);
                end
                CAND: begin
                    if (w_res == SINGLE && w_code == r_cand) begin
                        if (r_cnt + 1'b1 == CW'(DEBOUNCE_SCANS)) begin
                            w_state = PRESSED;
                            w_entry = r_cand;
                            w_btn   = 1'b1;
                            w_held  = 1'b1;
                            w_cnt   = '0;
                        end else w_cnt = r_cnt + 1'b1;
                    end else if (w_res == SINGLE) begin
                        w_cand = w_code;
                        w_cnt  = CW'(1);
                    end else begin
                        w_state = IDLE;
                        w_cnt   = '0;
                    end
                end
                PRESSED: if (w_res == NONE) begin
                    w_state = RELEASE;
                    w_cnt   = CW'(1);
                end
                RELEASE: begin
                    if (w_res != NONE) begin
                        w_state = PRESSED;
                        w_cnt   = '0;
                    end else if (r_cnt + 1'b1 == CW'(DEBOUNCE_SCANS)) begin
                        w_state = IDLE;
                        w_held  = 1'b0;
                        w_cnt   = '0;
                    end else w_cnt = r_cnt + 1'b1;
                end
            endcase
        end
    end
endmodule
